// File: rtl/al_accel_pkg.sv
// Shared definitions for the al_accel accumulation path.
// Holds the sequencer state encoding and the default datapath geometry that
// both al_accel_acc_seq and al_accel_acc_matrix are built around.
package al_accel_pkg;

   // Default widths / depths shared with the matrix datapath.
   localparam int unsigned DefChW      = 8;
   localparam int unsigned DefRowW     = 10;
   localparam int unsigned DefPipeLat  = 2;
   // Drain counter width; covers PIPE_LAT up to 15.
   localparam int unsigned DrainCntW   = 4;

   typedef enum logic [2:0] {
      StIdle,
      StAccum,
      StDrain,
      StOut,
      StDone
   } acc_seq_state_t;

endpackage

// File: rtl/al_accel_down_cnt.sv
// Loadable down-counter.
// Ports:
//   clk, resetn   clock, async active-low reset (count clears to 0)
//   load          load load_val this cycle (wins over dec)
//   load_val      value to load
//   dec           decrement by one; saturates at 0
//   count         current count
module al_accel_down_cnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/al_accel_acc_seq.sv
// Sequencer for the al_accel_acc_matrix accumulation datapath.
// Walks a job of cfg_num_rows rows, each made of cfg_num_ch channel beats,
// drives the matrix enable and bias / partial-sum load strobes, drains the
// matrix pipeline after each row and hands the row out on a valid/ready port.
// Ports:
//   clk, resetn                     clock, async active-low reset
//   start, cfg_num_ch, cfg_num_rows job start and config (latched in IDLE)
//   di_valid / di_ready             input beat handshake
//   out_valid / out_ready           finished-row handshake
//   enb                             matrix clock enable
//   acc_matrix_bps_load             seed accumulator from bias (first beat)
//   acc_matrix_inter_sum_load       accumulate onto partial sum (other beats)
//   ch_idx, row_idx                 current beat / row index
//   busy, done                      not-idle flag, job-complete pulse
module al_accel_acc_seq
   import al_accel_pkg::*;
#(
   parameter int unsigned CH_W     = DefChW,
   parameter int unsigned ROW_W    = DefRowW,
   parameter int unsigned PIPE_LAT = DefPipeLat
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [CH_W-1:0]  cfg_num_ch,
   input  logic [ROW_W-1:0] cfg_num_rows,
   input  logic             di_valid,
   output logic             di_ready,
   input  logic             out_ready,
   output logic             out_valid,
   output logic             enb,
   output logic             acc_matrix_bps_load,
   output logic             acc_matrix_inter_sum_load,
   output logic [CH_W-1:0]  ch_idx,
   output logic [ROW_W-1:0] row_idx,
   output logic             busy,
   output logic             done
);

   localparam logic [DrainCntW-1:0] DrainInit = DrainCntW'(PIPE_LAT);

   acc_seq_state_t   state_q, state_d;
   logic [CH_W-1:0]  num_ch_q, num_ch_d;
   logic [ROW_W-1:0] num_rows_q, num_rows_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic [ROW_W-1:0] row_q, row_d;

   logic                 drain_load;
   logic                 drain_dec;
   logic [DrainCntW-1:0] drain_cnt;

   al_accel_down_cnt #(
      .W (DrainCntW)
   ) u_drain_cnt (
      .clk      (clk),
      .resetn   (resetn),
      .load     (drain_load),
      .load_val (DrainInit),
      .dec      (drain_dec),
      .count    (drain_cnt)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         num_ch_q   <= '0;
         num_rows_q <= '0;
         ch_q       <= '0;
         row_q      <= '0;
      end else begin
         state_q    <= state_d;
         num_ch_q   <= num_ch_d;
         num_rows_q <= num_rows_d;
         ch_q       <= ch_d;
         row_q      <= row_d;
      end
   end

   always_comb begin
      state_d                   = state_q;
      num_ch_d                  = num_ch_q;
      num_rows_d                = num_rows_q;
      ch_d                      = ch_q;
      row_d                     = row_q;
      drain_load                = 1'b0;
      drain_dec                 = 1'b0;
      di_ready                  = 1'b0;
      out_valid                 = 1'b0;
      enb                       = 1'b0;
      acc_matrix_bps_load       = 1'b0;
      acc_matrix_inter_sum_load = 1'b0;
      busy                      = 1'b1;
      done                      = 1'b0;

      unique case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (start) begin
               num_ch_d   = cfg_num_ch;
               num_rows_d = cfg_num_rows;
               ch_d       = '0;
               row_d      = '0;
               // An empty job finishes without touching the matrix.
               if ((cfg_num_ch == '0) || (cfg_num_rows == '0)) begin
                  state_d = StDone;
               end else begin
                  state_d = StAccum;
               end
            end
         end

         StAccum: begin
            di_ready = 1'b1;
            if (di_valid) begin
               enb                       = 1'b1;
               acc_matrix_bps_load       = (ch_q == '0);
               acc_matrix_inter_sum_load = (ch_q != '0);
               ch_d                      = ch_q + CH_W'(1);
               if (ch_q == num_ch_q - CH_W'(1)) begin
                  drain_load = 1'b1;
                  state_d    = StDrain;
               end
            end
         end

         StDrain: begin
            // Both loads low: the matrix only advances its pipeline.
            enb       = 1'b1;
            drain_dec = 1'b1;
            if (drain_cnt == DrainCntW'(1)) begin
               state_d = StOut;
            end
         end

         StOut: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (row_q == num_rows_q - ROW_W'(1)) begin
                  state_d = StDone;
               end else begin
                  row_d   = row_q + ROW_W'(1);
                  ch_d    = '0;
                  state_d = StAccum;
               end
            end
         end

         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign ch_idx  = ch_q;
   assign row_idx = row_q;

endmodule

// File: doc/al_accel_acc_seq.md
# al_accel_acc_seq

Sequencer for the `al_accel_acc_matrix` 3x3x3 accumulation datapath inside the accelerator. It steps through a job of `cfg_num_rows` output rows, each built from `cfg_num_ch` input-channel beats. For each beat it drives the matrix enable and the bias/partial-sum select strobes. It drains the matrix pipeline after the last beat of a row and presents each finished row on a valid/ready output handshake. It sits between the line-buffer front end (`di_valid`/`di_ready`) and the result writer (`out_valid`/`out_ready`).

## Interface
- `CH_W`, 8: width of channel count and channel index.
- `ROW_W`, 10: width of row count and row index.
- `PIPE_LAT`, 2: matrix pipeline depth in cycles; drain length. Legal range is 1..15.

Ports:
- `clk`  in  1  the block's single clock.
- `resetn`  in  1  reset; asynchronous, active-low.
- `start`  in  1  job start; sampled only in IDLE.
- `cfg_num_ch`  in  CH_W  channel beats per row; latched on an accepted start.
- `cfg_num_rows`  in  ROW_W  rows per job; latched on an accepted start.
- `di_valid`  in  1  matrix input data (`di_*`, `bps_*`) valid this cycle.
- `di_ready`  out  1  sequencer accepts a beat.
- `out_ready`  in  1  downstream accepts the finished row.
- `out_valid`  out  1  matrix output holds a finished row.
- `enb`  out  1  matrix clock enable.
- `acc_matrix_bps_load`  out  1  seed accumulator from `bps_*`; set on the first beat of a row.
- `acc_matrix_inter_sum_load`  out  1  accumulate onto the intermediate sum; set on non-first beats.
- `ch_idx`  out  CH_W  current channel beat index.
- `row_idx`  out  ROW_W  current row index.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the job completes.

## Operation
- States are IDLE, ACCUM, DRAIN, OUT, DONE.
- **IDLE**
  - `start`=1 latches the config, clears `ch_idx`/`row_idx` and goes to ACCUM.
  - If either config value is 0, the block goes straight to DONE. No beats are taken and `out_valid` never rises.
- **ACCUM**
  - `di_ready`=1, decoded from state (Moore).
  - A beat fires when `di_valid`&`di_ready`. On a beat:
    - `enb`=1.
    - `acc_matrix_bps_load`=(`ch_idx`==0).
    - `acc_matrix_inter_sum_load`=(`ch_idx`!=0).
    - `ch_idx` increments.
  - These three strobes are combinational from `di_valid`.
  - If `di_valid`=0: `enb` and both load strobes are 0, so the matrix holds.
  - The beat with `ch_idx`==`cfg_num_ch`-1 moves the block to DRAIN, with the drain counter set to `PIPE_LAT`.
- **DRAIN**
  - Outputs: `di_ready`=0, `enb`=1, both load strobes 0. Both strobes low means the matrix propagates its pipeline with no new accumulation.
  - The counter decrements each cycle. At 1 the block goes to OUT.
- **OUT**
  - `out_valid`=1 and `enb`=0 (output frozen) until `out_ready`.
  - On the handshake:
    - If `row_idx`==`cfg_num_rows`-1, go to DONE.
    - Otherwise `row_idx` increments, `ch_idx` returns to 0 and the block goes back to ACCUM.
- **DONE**: `done`=1 for one cycle, then IDLE.
- Indexes hold their values after the job, until the next accepted start.
- `start` while `busy` is ignored.
- A config change while `busy` has no effect, because the values are latched.
- Counters compare against the latched values and never wrap, given legal config values.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- When `resetn` deasserts mid-job:
  - the state returns to IDLE immediately (asynchronous);
  - any partial row is discarded;
  - no `done` pulse is issued.
- The `start` cycle is T0. The first possible beat is T1.
- With `di_valid` held high and `out_ready` high, one row takes `cfg_num_ch` + `PIPE_LAT` + 1 cycles, from ACCUM entry to the OUT handshake.
- `out_valid` first rises at T1 + `cfg_num_ch` + `PIPE_LAT`.
- `done` rises the cycle after the last OUT handshake.
- There are no back-to-back rows: ACCUM is re-entered the cycle after the handshake.

## Structure
- Shared package `al_accel_pkg` holds:
  - the state enum `acc_seq_state_t`;
  - the default `CH_W`/`ROW_W`/`PIPE_LAT` constants, shared with `al_accel_acc_matrix`.
- One sub-module is natural: `al_accel_down_cnt`, a loadable down-counter used for the drain counter.
- The channel and row indexes are inline up-counters.

## Test plan
- Single row: `cfg_num_ch`=3, `cfg_num_rows`=1, `di_valid`=1, `out_ready`=1.
  - `bps_load`=1 at T1; `inter_sum_load`=1 at T2 and T3.
  - `out_valid` at T6; `done` at T7.
- Input stall: same config as the single-row case, with `di_valid`=0 on the 2nd beat for 2 cycles.
  - `enb`=0 and both load strobes are 0 while stalled.
  - `out_valid` shifts to T8.
- Output backpressure: `cfg_num_rows`=2, `out_ready`=0 for 4 cycles.
  - `out_valid` held for those 4 cycles with `enb`=0.
  - `row_idx` stays 0 until the handshake, then becomes 1 and `ch_idx` becomes 0.
- Zero config: `cfg_num_ch`=0 → `done` at T1, `out_valid` never rises, no `enb`.
- Reset mid-DRAIN: all outputs are 0 immediately. A new start then runs a clean single row with the same timing as the first scenario.
- `start` pulsed during ACCUM: no effect, and the latched config is unchanged.
